imem_fetch: RTL

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_if.sv | 35 +++
 rtl/imem_ram.sv | 24 ++
 rtl/imem_fetch.sv | 115 +++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch block: defaults, states, NOP.
// Optional build macro used by this block: IMEM_PARITY_EN.
package imem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [DATA_W_DEF-1:0] NOP = '0;

endpackage

// File: rtl/imem_if.sv
// Bundles the fetch request/response and program-load channels of imem_fetch.
// master = the side driving requests and loads, slave = the memory block.
interface imem_if
  import imem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_err;
  logic              run;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_data, ld_last,
    input  req_ready, rsp_valid, rsp_data, rsp_err, ld_ready, ld_err, run
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_data, ld_last,
    output req_ready, rsp_valid, rsp_data, rsp_err, ld_ready, ld_err, run
  );

endinterface

// File: rtl/imem_ram.sv
// Synchronous one-read/one-write word array; contents and read register are never reset.
module imem_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only moves on a read strobe, which lets the owner hold a stalled response.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory: loaded once in LOAD, then serves one-cycle-latency fetches in RUN.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int RA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HW_W  = $clog2(DEPTH + 1);
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  localparam logic [0:0] ST_LOAD = LOAD;
  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP);

  logic [0:0]       state;
  logic [HW_W-1:0]  hw;
  logic             ld_err_q;
  logic             rsp_valid_q;
  logic             rsp_ok_q;
  logic             rsp_err_q;

  logic [IDX_W-1:0] ld_idx;
  logic [IDX_W-1:0] rq_idx;
  logic             ld_fire;
  logic             ld_ok;
  logic             req_fire;
  logic             rq_ok;
  logic [RAM_W-1:0] ram_wdata;
  logic [RAM_W-1:0] ram_rdata;
  logic             par_bad;

  assign ld_idx   = bus.ld_addr[ADDR_W-1:2];
  assign rq_idx   = bus.req_addr[ADDR_W-1:2];
  assign ld_fire  = bus.ld_valid && (state == ST_LOAD);
  assign ld_ok    = (bus.ld_addr[1:0] == 2'b00) && (32'(ld_idx) < 32'(DEPTH));
  assign req_fire = bus.req_valid && bus.req_ready;
  // Only words below the high-water mark were loaded since the last reset.
  assign rq_ok    = (bus.req_addr[1:0] == 2'b00) && (32'(rq_idx) < 32'(DEPTH))
                    && (32'(rq_idx) < 32'(hw));

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {^bus.ld_data, bus.ld_data};
  assign par_bad   = rsp_ok_q && (^ram_rdata);
`else
  assign ram_wdata = bus.ld_data;
  assign par_bad   = 1'b0;
`endif

  imem_ram #(
    .WIDTH (RAM_W),
    .DEPTH (DEPTH),
    .AW    (RA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ld_fire && ld_ok),
    .waddr (RA_W'(ld_idx)),
    .wdata (ram_wdata),
    .re    (req_fire),
    .raddr (RA_W'(rq_idx)),
    .rdata (ram_rdata)
  );

  // Load-phase control: mode switch, high-water tracking and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_LOAD;
      hw       <= '0;
      ld_err_q <= 1'b0;
    end else if (ld_fire) begin
      if (ld_ok) begin
        if ((32'(ld_idx) + 32'd1) > 32'(hw)) hw <= HW_W'(32'(ld_idx) + 32'd1);
      end else begin
        ld_err_q <= 1'b1;
      end
      if (bus.ld_last) state <= ST_RUN;
    end
  end

  // Response slot: refilled on every accepted fetch, emptied when consumed with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_ok_q    <= rq_ok;
      rsp_err_q   <= !rq_ok;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = (state == ST_RUN) && (!rsp_valid_q || bus.rsp_ready);
  assign bus.ld_ready  = (state == ST_LOAD);
  assign bus.run       = (state == ST_RUN);
  assign bus.ld_err    = ld_err_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_ok_q ? ram_rdata[DATA_W-1:0] : NOP_WORD;
  assign bus.rsp_err   = rsp_err_q || par_bad;

endmodule
